// File: rtl/mem_stream_loader_pkg.sv
// mem_stream_loader_pkg: shared FSM state encoding and stream header geometry
package mem_stream_loader_pkg;

    typedef enum logic [2:0] {
        S_ADDR,
        S_CNT,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    localparam int HDR_ADDR_BYTES = 4;
    localparam int HDR_CNT_BYTES  = 2;

endpackage

// File: rtl/mem_stream_loader_byte_assembler.sv
// byte_assembler: packs little-endian bytes into 32-bit words, flags the 4th byte
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [23:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;

    // Shift new bytes in from the top so the first byte of a word lands in bits 7:0
    always_comb begin
        sr_d         = byte_valid_i ? {byte_i, sr_q[23:8]} : sr_q;
        cnt_d        = byte_valid_i ? cnt_q + 2'd1 : cnt_q;
        word_valid_o = byte_valid_i && (cnt_q == 2'd3);
        word_o       = {byte_i, sr_q};
    end

    // Assembly state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stream_loader.sv
// mem_stream_loader: parses a BASE/COUNT/data/CHK byte stream into memory word writes
module mem_stream_loader
    import mem_stream_loader_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_rst,
    output logic          done,
    output logic          error
);

    state_e        state_q, state_d;
    logic [2:0]    hdr_q, hdr_d;
    logic [31:0]   base_q, base_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic [7:0]    chk_q, chk_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          accept;
    logic [15:0]   cnt_full;
    logic          hdr_ok;
    logic          word_valid;
    logic [31:0]   word;

    assign in_ready  = (state_q == S_ADDR) || (state_q == S_CNT) ||
                       (state_q == S_DATA) || (state_q == S_CHK);
    assign accept    = in_valid && in_ready;
    assign cnt_full  = {in_data, cnt_q[15:8]};
    assign hdr_ok    = (base_q[1:0] == 2'b00) &&
                       ({3'b000, base_q[31:2]} + {17'd0, cnt_full} <= 33'(MEM_WORDS));
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign cpu_rst   = (state_q == S_DONE);

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (accept && (state_q == S_DATA)),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Next-state: header capture and validation, word write issue, checksum decision
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_ADDR: if (accept) begin
                base_d = {in_data, base_q[31:8]};
                chk_d  = chk_q ^ in_data;
                hdr_d  = hdr_q + 3'd1;
                if (hdr_q == 3'(HDR_ADDR_BYTES - 1)) begin
                    hdr_d   = '0;
                    state_d = S_CNT;
                end
            end
            S_CNT: if (accept) begin
                cnt_d = cnt_full;
                chk_d = chk_q ^ in_data;
                hdr_d = hdr_q + 3'd1;
                if (hdr_q == 3'(HDR_CNT_BYTES - 1)) begin
                    hdr_d   = '0;
                    state_d = !hdr_ok ? S_ERR : (cnt_full == 16'd0) ? S_CHK : S_DATA;
                end
            end
            S_DATA: if (accept) begin
                chk_d = chk_q ^ in_data;
                if (word_valid) begin
                    we_d    = 1'b1;
                    wdata_d = word;
                    addr_d  = AW'(base_q) + AW'({wcnt_q, 2'b00});
                    wcnt_d  = wcnt_q + 16'd1;
                    if (wcnt_q == cnt_q - 16'd1) state_d = S_CHK;
                end
            end
            S_CHK: if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
            default: state_d = state_q;
        endcase
    end

    // State and datapath registers; reset aborts any pending write
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_ADDR;
            hdr_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            chk_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            chk_q   <= chk_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: doc/mem_stream_loader.md
MEM_STREAM_LOADER -- requirements
Module: mem_stream_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the target data/instruction memory.
REQ-002 SHALL have parameter AW, default 32, meaning the width of the byte address output.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a byte is offered on in_data.
REQ-006 SHALL have port in_data, input, 8, meaning the stream byte.
REQ-007 SHALL have port in_ready, output, 1; a byte is accepted on a cycle with in_valid && in_ready.
REQ-008 SHALL have port mem_we, output, 1, a one-cycle memory word-write strobe.
REQ-009 SHALL have port mem_addr, output, AW, a word-aligned byte address.
REQ-010 SHALL have port mem_wdata, output, 32, the write data.
REQ-011 SHALL have port cpu_rst, output, 1, the active-low processor reset, held low while loading.
REQ-012 SHALL have port done, output, 1, level high after a successful load.
REQ-013 SHALL have port error, output, 1, level high after a failed load.

Function
REQ-014 Stream format SHALL be: 4 bytes BASE (byte address, little-endian), 2 bytes COUNT (words, little-endian), COUNT x 4 data bytes (each word little-endian, first byte = bits 7:0), then 1 byte CHK.
REQ-015 FSM states SHALL be S_ADDR, S_CNT, S_DATA, S_CHK, S_DONE, S_ERR; after reset the FSM is in S_ADDR.
REQ-016 in_ready SHALL be 1 in S_ADDR, S_CNT, S_DATA and S_CHK, and 0 in S_DONE and S_ERR.
REQ-017 Header validation SHALL occur on the cycle the 2nd COUNT byte is accepted: BASE[1:0]!=0, or BASE/4 + COUNT > MEM_WORDS, -> S_ERR.
REQ-018 A valid header with COUNT==0 SHALL go S_CNT -> S_CHK; otherwise S_CNT -> S_DATA.
REQ-019 On acceptance of the 4th byte of each word, the assembled word SHALL be registered: next cycle mem_we=1, mem_wdata=word, mem_addr=BASE+4*k for word index k (0-based).
REQ-020 mem_we SHALL be high for exactly one cycle per word; write latency SHALL be 1 cycle after the 4th byte; no backpressure is applied during a write.
REQ-021 After the last word's 4th byte is accepted, the FSM SHALL go to S_CHK.
REQ-022 CHK SHALL equal the XOR of all preceding stream bytes (header and data); on match -> S_DONE, on mismatch -> S_ERR, decided on the cycle CHK is accepted.
REQ-023 Cycles with in_valid=0 SHALL leave all state unchanged; byte/word counters SHALL advance only on accepted bytes.
REQ-024 The word counter SHALL be 16 bits; the address SHALL be computed as BASE + (k<<2) in AW bits.
REQ-025 cpu_rst SHALL be 0 in every state except S_DONE, where it is 1.
REQ-026 done SHALL be 1 only in S_DONE; error SHALL be 1 only in S_ERR; both states SHALL be terminal until reset.

Reset
REQ-027 When rst=0 at a clock edge: FSM -> S_ADDR; counters, checksum and assembly registers -> 0; mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, cpu_rst=0.
REQ-028 Reset mid-load SHALL abort without issuing any further mem_we; the next stream starts from BASE byte 0.

Structure
REQ-029 The FSM state encoding and the header length constants (4 address bytes, 2 count bytes) SHALL live in the shared processor package.
REQ-030 Byte-to-word assembly SHALL be one sub-module, byte_assembler (shift register plus 2-bit byte counter, emits word_valid); everything else is in mem_stream_loader.

Verification
REQ-031 Stream BASE=0x00000080, COUNT=2, words 0xDEADBEEF and 0x00000001, correct CHK -> mem_we at 0x80 with 0xDEADBEEF and at 0x84 with 0x00000001, then done=1, cpu_rst=1, in_ready=0.
REQ-032 Same stream with CHK XORed with 0x01 -> both writes occur, then error=1, done=0, cpu_rst=0.
REQ-033 BASE=0x00000082 -> error=1 after the 6th byte, with no mem_we.
REQ-034 MEM_WORDS=1024, BASE=0x00000FFC, COUNT=2 -> error=1 after the 6th byte, with no mem_we; the same BASE with COUNT=1 succeeds with a write at 0xFFC.
REQ-035 COUNT=0 with CHK=XOR of the 6 header bytes -> done=1, with zero mem_we pulses.
REQ-036 in_valid toggled randomly at 50% during REQ-031, then rst=0 for one cycle after the first word's write -> results identical to REQ-031 before the reset; after reset, FSM in S_ADDR, outputs 0, and no second write.
